// File: rtl/xup_match_pkg.sv
// xup_match_pkg
// Shared definitions for the match detector: the lock FSM state encoding
// and a saturating increment helper used by the run and total counters.
package xup_match_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    RUN    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_val;
    max_val = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_val) ? max_val : v + 32'd1;
  endfunction

endpackage

// File: rtl/xup_match_popcount.sv
// xup_popcount
// Purely combinational population count of a SIZE-bit vector.
// Ports:
//   bits  - input vector
//   count - number of ones in bits ($clog2(SIZE+1) bits)
module xup_popcount #(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0]            bits,
  output logic [$clog2(SIZE+1)-1:0]  count
);

  localparam int BC_W = $clog2(SIZE+1);

  always_comb begin
    count = '0;
    for (int i = 0; i < SIZE; i++) begin
      count = count + BC_W'(bits[i]);
    end
  end

endmodule

// File: rtl/xup_match_detector.sv
// xup_match_detector
// Registered back end for a per-bit equality vector. Stage 1 masks the
// vector and reduces it to a word-match flag and a matching-bit count.
// Stage 2 tracks runs of consecutive matching samples and locks once the
// run reaches the programmable threshold.
// Ports:
//   clk, reset     - rising-edge clock, asynchronous active-high reset
//   en             - sample strobe for eq_bits
//   clear          - synchronous clear of counters and FSM state
//   eq_bits, mask  - equality vector and participation mask (1 = compare)
//   threshold      - consecutive matches needed for lock (0 acts as 1)
//   match, match_valid, bit_count - stage-1 results and freshness strobe
//   run_count, total_count        - saturating run / total match counters
//   locked, lock_pulse, lost_pulse - lock state and entry/exit pulses
module xup_match_detector
  import xup_match_pkg::*;
#(
  parameter int SIZE  = 8,
  parameter int CNT_W = 8,
  parameter int BC_W  = $clog2(SIZE+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic [SIZE-1:0]  eq_bits,
  input  logic [SIZE-1:0]  mask,
  input  logic [CNT_W-1:0] threshold,
  output logic             match,
  output logic             match_valid,
  output logic [BC_W-1:0]  bit_count,
  output logic [CNT_W-1:0] run_count,
  output logic [CNT_W-1:0] total_count,
  output logic             locked,
  output logic             lock_pulse,
  output logic             lost_pulse
);

  logic [BC_W-1:0]  bc_comb;
  logic             match_comb;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] run_nxt, total_nxt, run_inc, t_eff;
  logic             lock_nxt, lost_nxt;

  // Masked-off bits count as equal for the word match, but not in the count.
  assign match_comb = &(eq_bits | ~mask);

  xup_popcount #(.SIZE(SIZE)) u_popcount (
    .bits  (eq_bits & mask),
    .count (bc_comb)
  );

  // ---- stage 1: mask and reduce ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match       <= 1'b0;
      bit_count   <= '0;
      match_valid <= 1'b0;
    end else if (clear) begin
      match_valid <= 1'b0;
    end else if (en) begin
      match       <= match_comb;
      bit_count   <= bc_comb;
      match_valid <= 1'b1;
    end else begin
      match_valid <= 1'b0;
    end
  end

  // ---- stage 2: run tracking and lock FSM ----
  assign t_eff   = (threshold == '0) ? CNT_W'(1) : threshold;
  assign run_inc = CNT_W'(sat_inc(32'(run_count), CNT_W));

  always_comb begin
    state_nxt = state;
    run_nxt   = run_count;
    total_nxt = total_count;
    lock_nxt  = 1'b0;
    lost_nxt  = 1'b0;
    if (clear) begin
      state_nxt = SEARCH;
      run_nxt   = '0;
      total_nxt = '0;
    end else if (match_valid) begin
      if (match) total_nxt = CNT_W'(sat_inc(32'(total_count), CNT_W));
      case (state)
        SEARCH: begin
          if (match) begin
            run_nxt = CNT_W'(1);
            if (t_eff == CNT_W'(1)) begin
              state_nxt = LOCKED;
              lock_nxt  = 1'b1;
            end else begin
              state_nxt = RUN;
            end
          end
        end
        RUN: begin
          if (match) begin
            run_nxt = run_inc;
            // Compare against the threshold as sampled now, so a lowered
            // threshold takes effect on the next matching sample.
            if (run_inc >= t_eff) begin
              state_nxt = LOCKED;
              lock_nxt  = 1'b1;
            end
          end else begin
            run_nxt   = '0;
            state_nxt = SEARCH;
          end
        end
        LOCKED: begin
          if (match) begin
            run_nxt = run_inc;
          end else begin
            run_nxt   = '0;
            state_nxt = SEARCH;
            lost_nxt  = 1'b1;
          end
        end
        default: begin
          run_nxt   = '0;
          state_nxt = SEARCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= SEARCH;
      run_count   <= '0;
      total_count <= '0;
      lock_pulse  <= 1'b0;
      lost_pulse  <= 1'b0;
    end else begin
      state       <= state_nxt;
      run_count   <= run_nxt;
      total_count <= total_nxt;
      lock_pulse  <= lock_nxt;
      lost_pulse  <= lost_nxt;
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_xup_match_detector.sv
// tb_xup_match_detector
// Directed bench for xup_match_detector: a default-sized instance plus a
// CNT_W=4 instance for counter saturation, sharing the sample stimulus.
module tb_xup_match_detector;

  logic       clk;
  logic       reset;
  logic       en;
  logic       clear;
  logic [7:0] eq_bits;
  logic [7:0] mask;
  logic [7:0] threshold;
  logic [3:0] threshold4;

  logic       match, match_valid, locked, lock_pulse, lost_pulse;
  logic [3:0] bit_count;
  logic [7:0] run_count, total_count;

  logic       match4, match_valid4, locked4, lock_pulse4, lost_pulse4;
  logic [3:0] bit_count4;
  logic [3:0] run_count4, total_count4;

  int n_checks = 0;
  int n_fail   = 0;

  xup_match_detector #(.SIZE(8), .CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .clear       (clear),
    .eq_bits     (eq_bits),
    .mask        (mask),
    .threshold   (threshold),
    .match       (match),
    .match_valid (match_valid),
    .bit_count   (bit_count),
    .run_count   (run_count),
    .total_count (total_count),
    .locked      (locked),
    .lock_pulse  (lock_pulse),
    .lost_pulse  (lost_pulse)
  );

  xup_match_detector #(.SIZE(8), .CNT_W(4)) dut4 (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .clear       (clear),
    .eq_bits     (eq_bits),
    .mask        (mask),
    .threshold   (threshold4),
    .match       (match4),
    .match_valid (match_valid4),
    .bit_count   (bit_count4),
    .run_count   (run_count4),
    .total_count (total_count4),
    .locked      (locked4),
    .lock_pulse  (lock_pulse4),
    .lost_pulse  (lost_pulse4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    en         = 1'b0;
    clear      = 1'b0;
    eq_bits    = 8'h00;
    mask       = 8'hFF;
    threshold  = 8'd3;
    threshold4 = 4'd0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_match", 32'(match), 0);
    chk("rst_mv", 32'(match_valid), 0);
    chk("rst_bc", 32'(bit_count), 0);
    chk("rst_run", 32'(run_count), 0);
    chk("rst_total", 32'(total_count), 0);
    chk("rst_locked", 32'(locked), 0);

    // Mask behaviour
    eq_bits = 8'hF7; mask = 8'hFF; en = 1'b1;
    tick();
    chk("maskA_match", 32'(match), 0);
    chk("maskA_bc", 32'(bit_count), 7);
    chk("maskA_mv", 32'(match_valid), 1);
    mask = 8'hF7;
    tick();
    chk("maskB_match", 32'(match), 1);
    chk("maskB_bc", 32'(bit_count), 7);
    chk("maskA_search_run", 32'(run_count), 0);
    eq_bits = 8'h00; mask = 8'h00;
    tick();
    chk("mask0_match", 32'(match), 1);
    chk("mask0_bc", 32'(bit_count), 0);
    chk("maskB_run", 32'(run_count), 1);
    chk("maskB_total", 32'(total_count), 1);
    en = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_run", 32'(run_count), 0);
    chk("clr_total", 32'(total_count), 0);
    chk("clr_mv", 32'(match_valid), 0);
    chk("clr_hold_match", 32'(match), 1);

    // Lock at threshold 3
    mask = 8'hFF; eq_bits = 8'hFF; threshold = 8'd3; en = 1'b1;
    tick();
    chk("lock_mv", 32'(match_valid), 1);
    chk("lock_run0", 32'(run_count), 0);
    tick();
    chk("lock_run1", 32'(run_count), 1);
    tick();
    chk("lock_run2", 32'(run_count), 2);
    chk("lock_not_yet", 32'(locked), 0);
    en = 1'b0;
    tick();
    chk("lock_run3", 32'(run_count), 3);
    chk("lock_locked", 32'(locked), 1);
    chk("lock_pulse", 32'(lock_pulse), 1);
    chk("lock_total", 32'(total_count), 3);
    tick();
    chk("lock_pulse_end", 32'(lock_pulse), 0);
    chk("lock_stays", 32'(locked), 1);

    // Loss of lock
    eq_bits = 8'h7F; en = 1'b1;
    tick();
    chk("loss_bc", 32'(bit_count), 7);
    en = 1'b0;
    tick();
    chk("loss_pulse", 32'(lost_pulse), 1);
    chk("loss_locked", 32'(locked), 0);
    chk("loss_run", 32'(run_count), 0);
    chk("loss_total", 32'(total_count), 3);
    tick();
    chk("loss_pulse_end", 32'(lost_pulse), 0);

    // Threshold 0 acts as 1
    threshold = 8'd0; eq_bits = 8'hFF; en = 1'b1;
    tick();
    en = 1'b0;
    chk("t0_no_pulse_yet", 32'(lock_pulse), 0);
    tick();
    chk("t0_pulse", 32'(lock_pulse), 1);
    chk("t0_locked", 32'(locked), 1);
    chk("t0_run", 32'(run_count), 1);
    chk("t0_total", 32'(total_count), 4);

    // Clear has priority over en while locked
    clear = 1'b1; en = 1'b1;
    tick();
    clear = 1'b0; en = 1'b0;
    chk("cp_locked", 32'(locked), 0);
    chk("cp_run", 32'(run_count), 0);
    chk("cp_total", 32'(total_count), 0);
    chk("cp_mv", 32'(match_valid), 0);
    chk("cp_lost", 32'(lost_pulse), 0);
    tick();
    chk("cp_lost_after", 32'(lost_pulse), 0);
    chk("cp_locked_after", 32'(locked), 0);

    // Threshold lowered mid-run
    threshold = 8'd5; en = 1'b1;
    tick();
    tick();
    tick();
    en = 1'b0;
    tick();
    chk("thr_run3", 32'(run_count), 3);
    chk("thr_not_locked", 32'(locked), 0);
    threshold = 8'd2;
    tick();
    chk("thr_no_force", 32'(locked), 0);
    chk("thr_no_force_pulse", 32'(lock_pulse), 0);
    en = 1'b1;
    tick();
    en = 1'b0;
    tick();
    chk("thr_lower_locked", 32'(locked), 1);
    chk("thr_lower_pulse", 32'(lock_pulse), 1);
    chk("thr_lower_run", 32'(run_count), 4);

    // Saturation on the 4-bit instance, 20 consecutive matches
    clear = 1'b1;
    tick();
    clear = 1'b0; en = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    en = 1'b0;
    tick();
    tick();
    chk("sat_run4", 32'(run_count4), 15);
    chk("sat_total4", 32'(total_count4), 15);
    chk("sat_locked4", 32'(locked4), 1);
    chk("sat_run8", 32'(run_count), 20);
    chk("sat_total8", 32'(total_count), 20);

    // Asynchronous reset between edges
    #3;
    reset = 1'b1;
    #1;
    chk("ar_match", 32'(match), 0);
    chk("ar_mv", 32'(match_valid), 0);
    chk("ar_bc", 32'(bit_count), 0);
    chk("ar_run", 32'(run_count), 0);
    chk("ar_total", 32'(total_count), 0);
    chk("ar_locked", 32'(locked), 0);
    chk("ar_lockp", 32'(lock_pulse), 0);
    chk("ar_lostp", 32'(lost_pulse), 0);
    chk("ar_total4", 32'(total_count4), 0);
    chk("ar_locked4", 32'(locked4), 0);
    tick();
    reset = 1'b0;

    // First sample after release is processed normally
    threshold = 8'd1; eq_bits = 8'hFF; mask = 8'hFF; en = 1'b1;
    tick();
    en = 1'b0;
    chk("rel_mv", 32'(match_valid), 1);
    chk("rel_match", 32'(match), 1);
    chk("rel_bc", 32'(bit_count), 8);
    tick();
    chk("rel_locked", 32'(locked), 1);
    chk("rel_pulse", 32'(lock_pulse), 1);
    chk("rel_run", 32'(run_count), 1);
    chk("rel_total", 32'(total_count), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
